// File: rtl/prd_dispatch.sv
// prd_dispatch: buffers 64-bit PRNG words in a small FIFO and serves
// OUT_BITS-wide slices to a masked datapath, LSB slice first, each bit once.
// Also sequences PRNG reseeds after a flush and counts consumer starvation.
module prd_dispatch #(
    parameter int DEPTH    = 4,
    parameter int OUT_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                rng_valid_i,
    input  logic [63:0]         rng_prd_i,
    output logic                rng_req_o,
    output logic                rng_reseed_o,
    input  logic                rand_ready_i,
    output logic                rand_valid_o,
    output logic [OUT_BITS-1:0] rand_o,
    output logic [15:0]         starve_cnt_o
);

    localparam int NSLICE = 64 / OUT_BITS;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_RESEED = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t             state_r;
    logic               reseed_r;
    logic [63:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic [IDX_W-1:0]   idx_r;
    logic               pending_r;
    logic               alive_r;      // low in the first cycle after reset
    logic [15:0]        starve_r;

    logic [CNT_W:0]     occ_s;
    logic               req_s;
    logic               valid_s;
    logic               handshake_s;
    logic               pop_s;
    logic               cap_s;
    logic [63:0]        word_s;
    logic [OUT_BITS-1:0] slice_s;

    // Request gating, handshake decode and slice selection.
    always_comb begin
        occ_s       = {1'b0, count_r} + {{CNT_W{1'b0}}, pending_r};
        req_s       = !rst_i && alive_r && (state_r == ST_RUN) && rng_valid_i
                      && (occ_s < DEPTH_W) && !flush_i;
        valid_s     = !rst_i && (count_r != {CNT_W{1'b0}}) && (state_r == ST_RUN);
        handshake_s = valid_s && rand_ready_i && !flush_i;
        pop_s       = handshake_s && (idx_r == LAST_IDX);
        cap_s       = pending_r && !flush_i;
        word_s      = mem_r[head_r];
        slice_s     = word_s[int'(idx_r) * OUT_BITS +: OUT_BITS];

        rng_req_o    = req_s;
        rand_valid_o = valid_s;
        if (valid_s) begin
            rand_o = slice_s;
        end else begin
            rand_o = {OUT_BITS{1'b0}};
        end
        rng_reseed_o = reseed_r;
        starve_cnt_o = starve_r;
    end

    // Reseed sequencer: flush forces RESEED from any state; the reseed pulse
    // is registered and coincides with the RESEED state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_RUN;
            reseed_r <= 1'b0;
        end else if (flush_i) begin
            state_r  <= ST_RESEED;
            reseed_r <= 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    state_r  <= ST_RUN;
                    reseed_r <= 1'b0;
                end
                ST_RESEED: begin
                    state_r  <= ST_WAIT;
                    reseed_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (rng_valid_i) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                    reseed_r <= 1'b0;
                end
                default: begin
                    state_r  <= ST_RUN;
                    reseed_r <= 1'b0;
                end
            endcase
        end
    end

    // Word FIFO, pending-capture flag and slice index; flush drops everything,
    // including a word whose request is still in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
            head_r    <= {PTR_W{1'b0}};
            tail_r    <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            pending_r <= 1'b0;
            alive_r   <= 1'b0;
        end else begin
            alive_r <= 1'b1;
            if (flush_i) begin
                head_r    <= {PTR_W{1'b0}};
                tail_r    <= {PTR_W{1'b0}};
                count_r   <= {CNT_W{1'b0}};
                idx_r     <= {IDX_W{1'b0}};
                pending_r <= 1'b0;
            end else begin
                pending_r <= req_s;
                if (cap_s) begin
                    mem_r[tail_r] <= rng_prd_i;
                    tail_r        <= tail_r + PTR_W'(1);
                end else begin
                    tail_r <= tail_r;
                end
                if (pop_s) begin
                    idx_r  <= {IDX_W{1'b0}};
                    head_r <= head_r + PTR_W'(1);
                end else if (handshake_s) begin
                    idx_r  <= idx_r + IDX_W'(1);
                end else begin
                    idx_r  <= idx_r;
                end
                case ({cap_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Saturating starvation counter; a flush cycle is never counted and only
    // reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_r <= 16'd0;
        end else if (rand_ready_i && !valid_s && !flush_i && (starve_r != 16'hFFFF)) begin
            starve_r <= starve_r + 16'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: tb/tb_prd_dispatch.sv
// Self-checking bench for prd_dispatch: the bench plays the PRNG, and a
// slice-queue reference model predicts every output cycle by cycle.
module tb_prd_dispatch;

    localparam int DEPTH = 4;
    localparam int OB    = 16;
    localparam int NS    = 64 / OB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready = 1'b0;
    logic [63:0]   prd = 64'd0;
    logic          req, reseed, valid;
    logic [OB-1:0] rand_v;
    logic [15:0]   starve_v;

    prd_dispatch #(.DEPTH(DEPTH), .OUT_BITS(OB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .rng_valid_i  (rvalid),
        .rng_prd_i    (prd),
        .rng_req_o    (req),
        .rng_reseed_o (reseed),
        .rand_ready_i (rready),
        .rand_valid_o (valid),
        .rand_o       (rand_v),
        .starve_cnt_o (starve_v)
    );

    always #5 clk = ~clk;

    // Reference model: queue of slices still to be served, in serving order.
    logic [OB-1:0] sq[$];
    logic [63:0]   forced_q[$];
    int            mstate = 0;     // 0 run, 1 reseed, 2 wait
    bit            pend = 1'b0;
    bit            alive = 1'b0;
    bit            rst_seen = 1'b0;
    logic [63:0]   cur_word = 64'd0;
    int            starve = 0;

    int n_vec = 0;
    int n_err = 0;
    int n_req = 0;
    int n_reseed = 0;
    int n_hs = 0;
    logic [OB-1:0] obs_rand;
    logic          obs_hs, obs_req, obs_valid, obs_reseed;
    logic [15:0]   obs_starve;

    task automatic step(input bit r, input bit f, input bit v, input bit rd);
        bit            ev;
        bit            er;
        bit            ers;
        logic [OB-1:0] erand;
        int            words;
        @(negedge clk);
        rst = r; flush = f; rvalid = v; rready = rd;
        if (pend) begin
            if (forced_q.size() > 0) cur_word = forced_q.pop_front();
            else cur_word = {$urandom, $urandom};
            prd = cur_word;
        end else begin
            prd = {$urandom, $urandom};
        end
        #1;
        words = (sq.size() + NS - 1) / NS;
        if (r) begin
            ev = 1'b0; er = 1'b0; erand = '0; ers = (mstate == 1);
        end else begin
            ev    = (mstate == 0) && (sq.size() > 0);
            erand = ev ? sq[0] : '0;
            er    = alive && (mstate == 0) && v && (words + int'(pend) < DEPTH) && !f;
            ers   = (mstate == 1);
        end
        if (!r || rst_seen) begin
            n_vec++;
            if (valid !== ev) begin n_err++; $display("FAIL rand_valid t=%0t got %b want %b", $time, valid, ev); end
            n_vec++;
            if (rand_v !== erand) begin n_err++; $display("FAIL rand t=%0t got %h want %h", $time, rand_v, erand); end
            n_vec++;
            if (req !== er) begin n_err++; $display("FAIL rng_req t=%0t got %b want %b", $time, req, er); end
            n_vec++;
            if (reseed !== ers) begin n_err++; $display("FAIL reseed t=%0t got %b want %b", $time, reseed, ers); end
            n_vec++;
            if (starve_v !== 16'(starve)) begin n_err++; $display("FAIL starve t=%0t got %0d want %0d", $time, starve_v, starve); end
        end
        if (req === 1'b1) n_req++;
        if (reseed === 1'b1) n_reseed++;
        obs_rand = rand_v; obs_req = req; obs_valid = valid; obs_reseed = reseed; obs_starve = starve_v;
        obs_hs = valid && rd && !f;
        @(posedge clk);
        if (r) begin
            sq.delete(); pend = 1'b0; mstate = 0; alive = 1'b0; starve = 0; rst_seen = 1'b1;
        end else begin
            alive = 1'b1;
            if (rd && !ev && !f && starve < 65535) starve++;
            if (f) begin
                sq.delete(); pend = 1'b0; mstate = 1;
            end else begin
                if (ev && rd) begin void'(sq.pop_front()); n_hs++; end
                if (pend) for (int k = 0; k < NS; k++) sq.push_back(cur_word[k*OB +: OB]);
                pend = er;
                if (mstate == 1) mstate = 2;
                else if (mstate == 2 && v) mstate = 0;
                n_vec++;
                if ((sq.size() + NS - 1) / NS + int'(pend) > DEPTH) begin
                    n_err++; $display("FAIL occupancy t=%0t got %0d want <=%0d", $time, (sq.size() + NS - 1) / NS + int'(pend), DEPTH);
                end
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({obs_req, obs_valid, obs_reseed} !== 3'b000 || obs_starve !== 16'd0 || obs_rand !== '0) begin
            n_err++; $display("FAIL reset_outputs got req%b val%b rs%b st%0d r%h want all zero", obs_req, obs_valid, obs_reseed, obs_starve, obs_rand);
        end
    endtask

    task automatic test_ramp();
        forced_q.push_back(64'h0123456789ABCDEF);
        n_req = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (n_req != DEPTH) begin n_err++; $display("FAIL ramp_requests got %0d want %0d", n_req, DEPTH); end
        n_vec++;
        if (obs_req !== 1'b0) begin n_err++; $display("FAIL ramp_full_req got %b want 0", obs_req); end
    endtask

    task automatic test_slicing();
        logic [OB-1:0] exp_sl [NS];
        exp_sl = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        for (int i = 0; i < NS; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (obs_rand !== exp_sl[i] || obs_hs !== 1'b1) begin
                n_err++; $display("FAIL slice%0d got %h hs%b want %h hs1", i, obs_rand, obs_hs, exp_sl[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs_hs !== 1'b1) begin n_err++; $display("FAIL next_word_gap got hs %b want 1", obs_hs); end
    endtask

    task automatic test_stream();
        int hs0;
        hs0 = n_hs;
        for (int i = 0; i < 1100; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (n_hs - hs0 < 1000) begin n_err++; $display("FAIL stream_slices got %0d want >=1000", n_hs - hs0); end
    endtask

    task automatic test_flush();
        bit seen;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (obs_hs !== 1'b0 && valid !== 1'b1) begin n_err++; $display("FAIL flush_handshake got hs %b want 0", obs_hs); end
        forced_q.delete();
        forced_q.push_back(64'hA5A55A5A1234BEEF);
        n_req = 0; n_reseed = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (obs_valid !== 1'b0 || obs_rand !== '0) begin
                n_err++; $display("FAIL flush_idle%0d got val %b rand %h want 0 0", i, obs_valid, obs_rand);
            end
        end
        n_vec++;
        if (n_reseed != 1) begin n_err++; $display("FAIL reseed_pulses got %0d want 1", n_reseed); end
        n_vec++;
        if (n_req != 0) begin n_err++; $display("FAIL req_while_invalid got %0d want 0", n_req); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            if (obs_hs) begin
                seen = 1'b1;
                n_vec++;
                if (obs_rand !== 16'hBEEF) begin n_err++; $display("FAIL post_reseed_slice got %h want beef", obs_rand); end
            end
        end
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL recovery_timeout got no slice want slice within 10 cycles"); end
    endtask

    task automatic test_starve();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs_starve !== 16'hFFFF) begin n_err++; $display("FAIL starve_sat got %h want ffff", obs_starve); end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (obs_starve !== 16'hFFFF) begin n_err++; $display("FAIL starve_flush got %h want ffff", obs_starve); end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (obs_starve !== 16'd0) begin n_err++; $display("FAIL starve_reset got %h want 0", obs_starve); end
    endtask

    task automatic test_reset_mid();
        int hs0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if ({obs_req, obs_valid, obs_reseed} !== 3'b000 || obs_starve !== 16'd0 || obs_rand !== '0) begin
            n_err++; $display("FAIL reset_mid_outputs got req%b val%b rs%b st%0d r%h want all zero", obs_req, obs_valid, obs_reseed, obs_starve, obs_rand);
        end
        hs0 = n_hs;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (n_hs == hs0) begin n_err++; $display("FAIL reset_mid_resume got 0 slices want >0"); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6));
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_slicing();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
        test_starve();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
